fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/pc_next.sv | 25 ++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cpu_pkg
// Brief   : Shared CPU constants: opcodes, fetch state encoding, widths.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int          INSTR_W  = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pc_next
// Brief   : Sequential / branch next-PC computation, modulo 2^32.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pc_next
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] ext_imm,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_offset;

  // Word offset to byte offset; the two top immediate bits fall off the end.
  assign w_offset   = ext_imm << 2;
  assign w_pc_plus4 = pc + 32'd4;
  assign next_pc    = pc_src ? (w_pc_plus4 + w_offset) : w_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : FETCH/ISSUE/HALT instruction fetch with IR and field decode.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               Reset,
  input  logic               PCWre,
  input  logic               PCSrc,
  input  logic [31:0]        ExtImm,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm16,
  output logic [31:0]        pc_out,
  output logic               halted
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [31:0]        r_pc;
  logic [31:0]        r_ir_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [31:0]        w_next_pc;

  pc_next u_pc_next (
    .pc      (r_pc),
    .pc_src  (PCSrc),
    .ext_imm (ExtImm),
    .next_pc (w_next_pc)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_RESET;
      r_ir_pc <= PC_RESET;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      // The IR and its address are captured together so pc_out stays tied
      // to the instruction even after the PC has moved on.
      if (r_state == ST_FETCH && imem_ack) begin
        r_ir    <= imem_rdata;
        r_ir_pc <= r_pc;
      end
      if (r_state == ST_ISSUE && PCWre) begin
        r_pc <= w_next_pc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FETCH: if (imem_ack) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = PCWre ? ST_FETCH : ST_HALT;
      ST_HALT:  w_state_next = ST_HALT;
      default:  w_state_next = ST_FETCH;
    endcase
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign halted      = (r_state == ST_HALT);
  assign pc_out      = r_ir_pc;
  assign opcode      = r_ir[31:26];
  assign rs          = r_ir[25:21];
  assign rt          = r_ir[20:16];
  assign rd          = r_ir[15:11];
  assign imm16       = r_ir[15:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Brief   : Scoreboard bench for fetch_unit: directed fetch/branch/halt/reset.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic        PCSrc;
  logic [31:0] ExtImm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] pc_out;
  logic        halted;

  int          checks = 0;
  int          failures = 0;
  int          valid_count = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .ExtImm(ExtImm),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .imm16(imm16), .pc_out(pc_out), .halted(halted)
  );

  // Every issue cycle pops one expected {pc, instr} pushed at ack time.
  always @(negedge CLK) begin
    if (Reset === 1'b1 && instr_valid === 1'b1) begin
      valid_count++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue pc_out=%h opcode=%b required=no_issue", pc_out, opcode);
      end else begin
        mon_exp = sb.pop_front();
        if ({pc_out, opcode, rs, rt, rd, imm16} !==
            {mon_exp[63:32], mon_exp[31:26], mon_exp[25:21], mon_exp[20:16],
             mon_exp[15:11], mon_exp[15:0]}) begin
          failures++;
          $display("FAIL issue_fields pc_out=%h op=%b rs=%0d rt=%0d rd=%0d imm=%h required pc=%h instr=%h",
                   pc_out, opcode, rs, rt, rd, imm16, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired required=finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_instr(input int delay, input logic [31:0] instr,
                             input logic wre, input logic src, input logic [31:0] ext,
                             output logic [31:0] addr, output int req_cycles);
    int waited = 0;
    req_cycles = 0;
    addr = 32'h0;
    while (imem_req !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout imem_req=%b required=1", imem_req);
      return;
    end
    addr = imem_addr;
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge CLK);
      req_cycles++;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr) begin
        failures++;
        $display("FAIL fetch_hold req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, addr);
      end
    end
    imem_ack = 1'b1;
    imem_rdata = instr;
    PCWre = wre;
    PCSrc = src;
    ExtImm = ext;
    sb.push_back({addr, instr});
    req_cycles++;
    @(negedge CLK);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL issue_state req=%b valid=%b required req=0 valid=1", imem_req, instr_valid);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    Reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    PCWre = 1'b0; PCSrc = 1'b0; ExtImm = 32'h0;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    checks++;
    if ({imem_req, instr_valid, halted, pc_out, imem_addr, opcode, rs, rt, rd, imm16} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'h0, 5'h0, 5'h0, 5'h0, 16'h0}) begin
      failures++;
      $display("FAIL reset_state req=%b valid=%b halted=%b pc_out=%h addr=%h op=%b imm=%h required 1 0 0 0 0 0 0",
               imem_req, instr_valid, halted, pc_out, imem_addr, opcode, imm16);
    end
  endtask

  task automatic test_first_fetch();
    logic [31:0] a; int n;
    issue_instr(0, 32'h0401_0005, 1'b1, 1'b0, 32'h0, a, n);
    checks++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h4 || opcode !== 6'b000001 || imm16 !== 16'h5) begin
      failures++;
      $display("FAIL first_fetch_after valid=%b addr=%h op=%b imm=%h required 0 00000004 000001 0005",
               instr_valid, imem_addr, opcode, imm16);
    end
  endtask

  task automatic test_ack_delay();
    logic [31:0] a; int n; int v0;
    v0 = valid_count;
    issue_instr(3, 32'h0022_1820, 1'b1, 1'b0, 32'h0, a, n);
    repeat (2) @(negedge CLK);
    checks++;
    if (n !== 4 || a !== 32'h4) begin
      failures++;
      $display("FAIL ack_delay_req req_cycles=%0d addr=%h required 4 00000004", n, a);
    end
    checks++;
    if (valid_count - v0 !== 1) begin
      failures++;
      $display("FAIL ack_delay_pulses pulses=%0d required=1", valid_count - v0);
    end
  endtask

  task automatic test_branch();
    logic [31:0] a; int n;
    issue_instr(0, 32'h1111_0001, 1'b1, 1'b0, 32'h0, a, n);
    issue_instr(1, 32'h2222_0002, 1'b1, 1'b0, 32'h0, a, n);
    checks++;
    if (imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL branch_setup addr=%h required=00000010", imem_addr);
    end
    issue_instr(0, 32'hC000_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFE, a, n);
    checks++;
    if (imem_addr !== 32'h0000_000C) begin
      failures++;
      $display("FAIL branch_back addr=%h required=0000000C", imem_addr);
    end
    issue_instr(0, 32'h3333_0003, 1'b1, 1'b0, 32'h0, a, n);
    issue_instr(2, 32'h4444_0004, 1'b1, 1'b0, 32'h0, a, n);
    checks++;
    if (a !== 32'h10 || imem_addr !== 32'h14) begin
      failures++;
      $display("FAIL branch_not_taken from=%h addr=%h required from=00000010 addr=00000014", a, imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a; int n;
    issue_instr(0, 32'hC000_FFF9, 1'b1, 1'b1, 32'hBFFF_FFF9, a, n);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL branch_imm_top_bits addr=%h required=FFFFFFFC", imem_addr);
    end
    issue_instr(1, 32'h5555_0005, 1'b1, 1'b0, 32'h0, a, n);
    checks++;
    if (a !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap from=%h addr=%h required from=FFFFFFFC addr=00000000", a, imem_addr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] a; int n;
    issue_instr(0, 32'hFC00_ABCD, 1'b0, 1'b1, 32'h0000_0010, a, n);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({halted, imem_req, instr_valid, imem_addr, pc_out, opcode, imm16} !==
          {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'b111111, 16'hABCD}) begin
        failures++;
        $display("FAIL halt_hold cyc=%0d halted=%b req=%b valid=%b addr=%h pc_out=%h op=%b imm=%h required 1 0 0 0 0 111111 abcd",
                 i, halted, imem_req, instr_valid, imem_addr, pc_out, opcode, imm16);
      end
      imem_ack = (i % 2 == 0);
      imem_rdata = 32'h1234_5678;
      PCWre = 1'b1;
      @(negedge CLK);
    end
    imem_ack = 1'b0;
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    checks++;
    if ({halted, imem_req, imem_addr, opcode, pc_out} !== {1'b0, 1'b1, 32'h0, 6'h0, 32'h0}) begin
      failures++;
      $display("FAIL halt_exit halted=%b req=%b addr=%h op=%b pc_out=%h required 0 1 0 0 0",
               halted, imem_req, imem_addr, opcode, pc_out);
    end
  endtask

  task automatic test_reset_ack();
    logic [31:0] a; int n;
    issue_instr(0, 32'h8C4A_1234, 1'b1, 1'b0, 32'h0, a, n);
    Reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    checks++;
    if ({instr_valid, opcode, rs, rt, rd, imm16, pc_out} !== {1'b0, 6'h0, 5'h0, 5'h0, 5'h0, 16'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_ack_ir valid=%b op=%b rs=%0d rt=%0d imm=%h pc_out=%h required all zero",
               instr_valid, opcode, rs, rt, imm16, pc_out);
    end
    Reset = 1'b1;
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_ack_addr req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a; int n;
    logic [31:0] exp_pc, ins, ext;
    logic src;
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      ins = $urandom;
      src = 1'($urandom_range(0, 1));
      ext = $urandom_range(0, 15);
      ext = ext - 32'd8;
      issue_instr(int'($urandom_range(0, 2)), ins, 1'b1, src, ext, a, n);
      checks++;
      if (a !== exp_pc) begin
        failures++;
        $display("FAIL b2b_fetch_addr i=%0d addr=%h required=%h", i, a, exp_pc);
      end
      exp_pc = exp_pc + 32'd4 + (src ? {ext[29:0], 2'b00} : 32'h0);
    end
    checks++;
    if (imem_addr !== exp_pc || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_final addr=%h pending=%0d required addr=%h pending=0", imem_addr, sb.size(), exp_pc);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_ack_delay();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_ack();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
